// File: rtl/fir_pkg.sv
// Shared definitions for the 2D FIR path: Q1.12 constants, FSM states and
// the round/clamp used by both the vertical and horizontal stages.
package fir_pkg;

    localparam int FRAC_BITS = 12;
    localparam int ROUND_BIT = 11;
    localparam int DIM_W     = 11;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH
    } fir_state_t;

    // Sum of three 9x14 products to an unsigned 8-bit pixel.
    function automatic logic [7:0] round_clamp(input logic signed [24:0] sum);
        logic signed [24:0] t;
        t = sum + $signed(25'(1 << ROUND_BIT));
        if (t[24])
            return '0;
        else if (|t[23:FRAC_BITS+8])
            return '1;
        else
            return t[FRAC_BITS+7:FRAC_BITS];
    endfunction

endpackage

// File: rtl/vline_ram.sv
// Simple 1R1W synchronous line buffer; read returns the old word on a
// same-address write.
module vline_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vfilter_lbuf.sv
// Vertical 3-tap FIR over a raster stream using two line buffers; emits one
// filtered pixel plus the raw centre pixel per input position, 3-cycle latency.
module vfilter_lbuf
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int COEFF_WIDTH = 14,
    parameter int MAX_WIDTH   = 1024,
    parameter int DIM_W       = fir_pkg::DIM_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic                   sof_i,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic [DIM_W-1:0]       line_width_i,
    input  logic [DIM_W-1:0]       img_height_i,
    input  logic [COEFF_WIDTH-1:0] coeff0_v_i,
    input  logic [COEFF_WIDTH-1:0] coeff1_v_i,
    input  logic [COEFF_WIDTH-1:0] coeff2_v_i,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic [DATA_WIDTH-1:0]  center_o,
    output logic                   valid_o
);

    localparam int AW = $clog2(MAX_WIDTH);
    localparam int PW = DATA_WIDTH + 1 + COEFF_WIDTH;
    localparam int SW = PW + 2;

    fir_state_t       state, state_n;
    logic [DIM_W-1:0] col, col_n, row, row_n;
    logic [DIM_W-1:0] width_r, width_n, height_r, height_n;
    logic [DIM_W-1:0] w_in, h_in;
    logic             accept, sof_acc, last_col, last_row;
    logic             store, emit0, first0, flush0;
    logic [AW-1:0]    addr0;

    logic [DATA_WIDTH-1:0] lb1_rd, lb2_rd, lb2_eff;
    logic [DATA_WIDTH-1:0] tap_top, tap_mid, tap_bot;

    logic                  s1_store, s1_emit, s1_first, s1_flush, s1_h1;
    logic [AW-1:0]         s1_col;
    logic [DATA_WIDTH-1:0] s1_new;
    logic                  fwd_en;
    logic [AW-1:0]         fwd_addr;
    logic [DATA_WIDTH-1:0] fwd_data;

    logic                  s2_emit;
    logic signed [PW-1:0]  p0, p1, p2;
    logic [DATA_WIDTH-1:0] s2_center;

    logic signed [SW-1:0]  sum_r;
    logic [DATA_WIDTH-1:0] center_r;
    logic                  valid_r;

    always_comb begin
        w_in = line_width_i;
        if (line_width_i == '0)
            w_in = DIM_W'(1);
        else if (line_width_i > DIM_W'(MAX_WIDTH))
            w_in = DIM_W'(MAX_WIDTH);
        h_in = (img_height_i == '0) ? DIM_W'(1) : img_height_i;
    end

    assign ready_o  = !rst && (state != FLUSH);
    assign accept   = valid_i && ready_o;
    assign sof_acc  = accept && sof_i;
    assign last_col = (col == width_r - DIM_W'(1));
    assign last_row = (row == height_r - DIM_W'(1));

    // A one-pixel-wide frame finishes row 0 on the sof pixel itself, so FILL is skipped.
    always_comb begin
        state_n  = state;
        col_n    = col;
        row_n    = row;
        width_n  = width_r;
        height_n = height_r;
        store    = 1'b0;
        emit0    = 1'b0;
        first0   = 1'b0;
        flush0   = 1'b0;
        addr0    = col[AW-1:0];
        if (sof_acc) begin
            width_n  = w_in;
            height_n = h_in;
            store    = 1'b1;
            addr0    = '0;
            row_n    = '0;
            if (w_in == DIM_W'(1)) begin
                col_n = '0;
                if (h_in > DIM_W'(1)) begin
                    row_n   = DIM_W'(1);
                    state_n = RUN;
                end else begin
                    state_n = FLUSH;
                end
            end else begin
                col_n   = DIM_W'(1);
                state_n = FILL;
            end
        end else begin
            case (state)
                FILL: if (accept) begin
                    store = 1'b1;
                    if (last_col) begin
                        col_n   = '0;
                        row_n   = DIM_W'(1);
                        state_n = (height_r > DIM_W'(1)) ? RUN : FLUSH;
                    end else begin
                        col_n = col + DIM_W'(1);
                    end
                end
                RUN: if (accept) begin
                    store  = 1'b1;
                    emit0  = 1'b1;
                    first0 = (row == DIM_W'(1));
                    if (last_col) begin
                        col_n = '0;
                        if (last_row) begin
                            row_n   = '0;
                            state_n = FLUSH;
                        end else begin
                            row_n = row + DIM_W'(1);
                        end
                    end else begin
                        col_n = col + DIM_W'(1);
                    end
                end
                FLUSH: begin
                    emit0  = 1'b1;
                    flush0 = 1'b1;
                    if (last_col) begin
                        col_n   = '0;
                        state_n = IDLE;
                    end else begin
                        col_n = col + DIM_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            col      <= '0;
            row      <= '0;
            width_r  <= '0;
            height_r <= '0;
        end else begin
            state    <= state_n;
            col      <= col_n;
            row      <= row_n;
            width_r  <= width_n;
            height_r <= height_n;
        end
    end

    vline_ram #(.DEPTH(MAX_WIDTH), .WIDTH(DATA_WIDTH)) u_lb1 (
        .clk   (clk),
        .we    (store),
        .waddr (addr0),
        .wdata (data_i),
        .raddr (addr0),
        .rdata (lb1_rd)
    );

    // lb2 takes lb1's old word one cycle late, once it has been read out.
    vline_ram #(.DEPTH(MAX_WIDTH), .WIDTH(DATA_WIDTH)) u_lb2 (
        .clk   (clk),
        .we    (s1_store),
        .waddr (s1_col),
        .wdata (lb1_rd),
        .raddr (addr0),
        .rdata (lb2_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_store <= 1'b0;
            s1_emit  <= 1'b0;
            fwd_en   <= 1'b0;
        end else begin
            s1_store <= store;
            s1_emit  <= emit0;
            fwd_en   <= s1_store;
        end
        s1_first <= first0;
        s1_flush <= flush0;
        s1_h1    <= (height_r == DIM_W'(1));
        s1_col   <= addr0;
        s1_new   <= data_i;
        fwd_addr <= s1_col;
        fwd_data <= lb1_rd;
    end

    // The delayed lb2 write races the next read only on one-pixel-wide lines.
    assign lb2_eff = (fwd_en && fwd_addr == s1_col) ? fwd_data : lb2_rd;
    assign tap_mid = lb1_rd;
    assign tap_top = (s1_first || (s1_flush && s1_h1)) ? lb1_rd : lb2_eff;
    assign tap_bot = s1_flush ? lb1_rd : s1_new;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_emit  <= 1'b0;
            valid_r  <= 1'b0;
            sum_r    <= '0;
            center_r <= '0;
        end else begin
            s2_emit  <= s1_emit;
            valid_r  <= s2_emit;
            sum_r    <= {{2{p0[PW-1]}}, p0} + {{2{p1[PW-1]}}, p1} + {{2{p2[PW-1]}}, p2};
            center_r <= s2_center;
        end
        p0        <= PW'($signed({1'b0, tap_top})) * PW'($signed(coeff0_v_i));
        p1        <= PW'($signed({1'b0, tap_mid})) * PW'($signed(coeff1_v_i));
        p2        <= PW'($signed({1'b0, tap_bot})) * PW'($signed(coeff2_v_i));
        s2_center <= tap_mid;
    end

    assign data_o   = round_clamp(sum_r);
    assign center_o = center_r;
    assign valid_o  = valid_r;

endmodule

// File: tb/tb_vfilter_lbuf.sv
// Directed bench for vfilter_lbuf: a frame model fills an expected-output
// queue, and a negedge monitor pops and checks every valid_o beat.
module tb_vfilter_lbuf;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, sof_i, ready_o, valid_o;
    logic [7:0]  data_i, data_o, center_o;
    logic [10:0] lw, ih;
    logic [13:0] c0, c1, c2;

    always #5 clk = ~clk;

    vfilter_lbuf #(.DATA_WIDTH(8), .COEFF_WIDTH(14), .MAX_WIDTH(1024), .DIM_W(11)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .sof_i        (sof_i),
        .data_i       (data_i),
        .line_width_i (lw),
        .img_height_i (ih),
        .coeff0_v_i   (c0),
        .coeff1_v_i   (c1),
        .coeff2_v_i   (c2),
        .data_o       (data_o),
        .center_o     (center_o),
        .valid_o      (valid_o)
    );

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] c;
    } exp_t;

    exp_t q[$];
    int   fr [0:7][0:15];
    int   cyc = 0;
    int   n_vec = 0, n_err = 0, out_cnt = 0;
    int   first_out_cyc = -1, row1_pres = 0, last_pres = 0;
    bit   chk_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sx14(input logic [13:0] v);
        return v[13] ? int'(v) - 16384 : int'(v);
    endfunction

    function automatic logic [7:0] ref_px(input int t, input int m, input int b);
        int s;
        s = t * sx14(c0) + m * sx14(c1) + b * sx14(c2) + 2048;
        if (s < 0) return 8'd0;
        if (s >= (1 << 20)) return 8'd255;
        return 8'(s / 4096);
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Expected outputs of a w x h frame, edge rows replicated, first nout in raster order.
    task automatic push_exp(input int w, input int h, input int nout);
        int k = 0;
        exp_t e;
        for (int n = 0; n < h; n++)
            for (int c = 0; c < w; c++)
                if (k < nout) begin
                    e.d = ref_px(fr[(n == 0) ? 0 : n - 1][c], fr[n][c],
                                 fr[(n == h - 1) ? n : n + 1][c]);
                    e.c = 8'(fr[n][c]);
                    q.push_back(e);
                    k++;
                end
    endtask

    task automatic send(input logic [7:0] d, input bit s, input int wd, input int hd);
        @(negedge clk);
        valid_i = 1'b1;
        sof_i   = s;
        data_i  = d;
        lw      = 11'(wd);
        ih      = 11'(hd);
        for (int k = 0; k < 50 && !ready_o; k++) @(negedge clk);
        if (!ready_o) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout observed=0 expected=1");
        end
        last_pres = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input int w, input int h, input int npix, input int wd, input int hd);
        int idx = 0;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                if (idx < npix) begin
                    send(8'(fr[r][c]), idx == 0, wd, hd);
                    if (idx == w) row1_pres = last_pres;
                    idx++;
                end
        @(negedge clk);
        valid_i = 1'b0;
        sof_i   = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 400 && q.size() != 0; k++) @(negedge clk);
        for (int k = 0; k < 50 && !ready_o; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk(tag, q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (chk_en && valid_o) begin
            exp_t e;
            out_cnt++;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output data=%0d center=%0d expected=none", data_o, center_o);
            end else begin
                e = q.pop_front();
                assert ((data_o === e.d) && (center_o === e.c)) else begin
                    n_err++;
                    $error("FAIL pixel data=%0d center=%0d expected data=%0d center=%0d",
                           data_o, center_o, e.d, e.c);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, snap;
        rst = 1'b1; valid_i = 1'b0; sof_i = 1'b0; data_i = '0;
        lw = '0; ih = '0; c0 = '0; c1 = 14'h1000; c2 = '0;
        @(negedge clk);
        chk("ready_in_reset", ready_o, 0);
        rst = 1'b0;
        #1;
        chk("reset_ready", ready_o, 1);
        chk("reset_valid", valid_o, 0);
        chk("reset_data", data_o, 0);
        chk("reset_center", center_o, 0);

        // identity 4x3 ramp, plus latency from row 1 col 0 to first output
        for (int r = 0; r < 3; r++) for (int c = 0; c < 4; c++) fr[r][c] = r * 4 + c;
        out_cnt = 0; first_out_cyc = -1;
        push_exp(4, 3, 12);
        drive_frame(4, 3, 12, 4, 3);
        wait_drain("drain_ident");
        chk("count_ident", out_cnt, 12);
        chk("latency", first_out_cyc - row1_pres, 3);

        // 1/3 averaging, constant rows 30/60/90 -> 40/60/80
        c0 = 14'h0555; c1 = 14'h0555; c2 = 14'h0555;
        for (int c = 0; c < 4; c++) begin fr[0][c] = 30; fr[1][c] = 60; fr[2][c] = 90; end
        push_exp(4, 3, 12);
        drive_frame(4, 3, 12, 4, 3);
        wait_drain("drain_avg");

        // one-pixel-wide column
        fr[0][0] = 10; fr[1][0] = 100; fr[2][0] = 250;
        push_exp(1, 3, 3);
        drive_frame(1, 3, 3, 1, 3);
        wait_drain("drain_w1");

        // negative clamp
        c0 = 14'h3000; c1 = 14'h1000; c2 = '0;
        fr[0][0] = 200; fr[0][1] = 200; fr[1][0] = 10; fr[1][1] = 10;
        push_exp(2, 2, 4);
        drive_frame(2, 2, 4, 2, 2);
        wait_drain("drain_neg");

        // positive clamp on a 1x1 frame, then 0x0 dimensions treated as 1x1
        c0 = '0; c1 = 14'h1FFF; c2 = '0;
        fr[0][0] = 255;
        push_exp(1, 1, 1);
        drive_frame(1, 1, 1, 1, 1);
        wait_drain("drain_pos");
        c1 = 14'h1000;
        fr[0][0] = 77;
        out_cnt = 0;
        push_exp(1, 1, 1);
        drive_frame(1, 1, 1, 0, 0);
        wait_drain("drain_dim0");
        chk("count_dim0", out_cnt, 1);

        // height 1: five flush cycles with ready_o low
        for (int c = 0; c < 5; c++) fr[0][c] = c * 50 + 5;
        push_exp(5, 1, 5);
        drive_frame(5, 1, 5, 5, 1);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (!ready_o) cnt++;
            @(negedge clk);
        end
        chk("flush_ready_low", cnt, 5);
        wait_drain("drain_h1");

        // restart: frame A 8x4 cut at row 2 col 3 by frame B 4x2
        for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) fr[r][c] = r * 16 + c + 1;
        out_cnt = 0;
        push_exp(8, 4, 11);
        drive_frame(8, 4, 19, 8, 4);
        for (int r = 0; r < 2; r++) for (int c = 0; c < 4; c++) fr[r][c] = 200 + r * 4 + c;
        push_exp(4, 2, 8);
        drive_frame(4, 2, 8, 4, 2);
        wait_drain("drain_restart");
        chk("count_restart", out_cnt, 19);

        // non-sof pixels in IDLE are dropped
        snap = out_cnt;
        for (int k = 0; k < 3; k++) send(8'(k + 9), 1'b0, 4, 2);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_drop", out_cnt, snap);

        // reset during FLUSH
        chk_en = 1'b0;
        for (int r = 0; r < 2; r++) for (int c = 0; c < 8; c++) fr[r][c] = 100 + r * 8 + c;
        drive_frame(8, 2, 16, 8, 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_flush_valid", valid_o, 0);
        chk("rst_flush_data", data_o, 0);
        chk("rst_flush_ready", ready_o, 1);
        q.delete();
        chk_en = 1'b1;
        snap = out_cnt;
        send(8'd42, 1'b0, 2, 2);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst_idle_drop", out_cnt, snap);
        fr[0][0] = 1; fr[0][1] = 2; fr[1][0] = 3; fr[1][1] = 4;
        push_exp(2, 2, 4);
        drive_frame(2, 2, 4, 2, 2);
        wait_drain("drain_after_rst");
        chk("count_after_rst", out_cnt, snap + 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vfilter_lbuf.md
Name: vfilter_lbuf

Overview:
- Vertical 3-tap FIR stage with two internal line buffers.
- Sits directly upstream of the horizontal filter in the 2D FIR path.
- Consumes a raster pixel stream and emits one vertically filtered pixel per input pixel position.
- Also emits the raw centre-row pixel, aligned with the filtered pixel, for the horizontal stage's centre input.

Parameters:
- DATA_WIDTH, 8: pixel width, unsigned.
- COEFF_WIDTH, 14: signed Q1.12 coefficient width (14'h1000 = 1.0).
- MAX_WIDTH, 1024: maximum line length; sets line buffer depth.
- DIM_W, 11: width of column/row counters and dimension inputs.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- valid_i  in  1  input pixel valid
- ready_o  out  1  block accepts a pixel this cycle
- sof_i  in  1  marks first pixel of a frame; qualified by valid_i && ready_o
- data_i  in  DATA_WIDTH  input pixel
- line_width_i  in  DIM_W  pixels per line; sampled on an accepted sof
- img_height_i  in  DIM_W  lines per frame; sampled on an accepted sof
- coeff0_v_i  in  COEFF_WIDTH  tap for the oldest row (row above centre)
- coeff1_v_i  in  COEFF_WIDTH  tap for the centre row
- coeff2_v_i  in  COEFF_WIDTH  tap for the newest row (row below centre)
- data_o  out  DATA_WIDTH  filtered pixel, rounded and clamped
- center_o  out  DATA_WIDTH  raw centre-row pixel, aligned with data_o
- valid_o  out  1  data_o/center_o valid

Behaviour:
- Reset (synchronous):
  - FSM goes to IDLE; all counters and pipeline valids clear.
  - valid_o=0, data_o=0, center_o=0.
  - ready_o=0 during the reset cycle and =1 from the next cycle.
  - Line buffer contents are not reset.
- Accept rule: a pixel is accepted when valid_i && ready_o.
- ready_o is 1 in IDLE, FILL and RUN, and 0 in FLUSH.
- No downstream backpressure.
- Dimensions: a sampled width or height of 0 is treated as 1; a width above MAX_WIDTH is clamped to MAX_WIDTH.
- Line buffers lb1 (row n-1) and lb2 (row n-2):
  - Each is 1R1W, synchronous, read-first at the same address.
  - On each accepted pixel at column c: lb2[c] <= lb1[c] and lb1[c] <= data_i.
- FSM:
  - IDLE: accepted pixels without sof are dropped. An accepted sof pixel is written as row 0, col 0; go to FILL.
  - FILL: stores row 0 and produces no output. At the end of row 0, go to RUN if height>1, else go to FLUSH.
  - RUN: each accepted pixel of row n (n>=1) at column c emits output row n-1 at column c.
    - Taps are (lb2[c], lb1[c], data_i).
    - For n=1 the top tap is lb1[c], replicating the top edge.
    - After the last pixel (row height-1, col width-1), go to FLUSH.
  - FLUSH: internally sweeps c = 0..width-1, one per cycle, emitting the last row with taps (lb2[c], lb1[c], lb1[c]), replicating the bottom edge.
    - If height==1, all three taps are lb1[c].
    - Then go to IDLE.
- Frame restart: an accepted sof in FILL or RUN restarts the frame, resamples the dimensions, treats the pixel as row 0 col 0, and goes to FILL. Outputs already in flight still emerge.
- Output count: exactly width*height valid_o pulses per completed frame, in raster order.
- Pipeline, fixed 3-cycle latency:
  - Cycle T: pixel accepted or flush column issued; line buffer read.
  - Cycle T+1: tap registers.
  - Cycle T+2: products.
  - Cycle T+3: sum register. valid_o is high and data_o/center_o are valid in this cycle.
  - data_o is combinational from the sum register.
- Arithmetic:
  - Each pixel is zero-extended to DATA_WIDTH+1 bits signed and multiplied by its signed coefficient, giving a 23-bit product.
  - The three products are sign-extended and summed to 25 bits.
- Round and clamp:
  - Add 2^11 to the sum.
  - If the result is negative, data_o=0.
  - Else if any bit above bit 19 is set, data_o=255.
  - Else data_o = bits [19:12].
- center_o is the raw centre tap delayed to align with data_o.

Decomposition:
- Shared package (fir_pkg): Q-format constants (FRAC_BITS=12, ROUND_BIT=11), DIM_W, and the FSM state enum (IDLE/FILL/RUN/FLUSH).
- The round/clamp function goes in the same package so the horizontal stage can reuse it.
- Sub-module vline_ram: parameterised depth/width 1R1W read-first RAM, instantiated twice.

Test Plan:
- 4x3 frame, coeffs (0, 14'h1000, 0), pixels 0..11 -> 12 outputs, data_o == center_o == input in raster order; first valid_o 3 cycles after the first pixel of row 1.
- 4x3 frame, coeffs all 14'h0555, rows constant 30/60/90 -> output rows 40, 60, 80 (edge replication: (30+30+60)/3 = 40).
- Coeffs (14'h3000, 14'h1000, 0) = (-1.0, 1.0, 0), row0=200, row1=10 -> data_o = 0 (negative clamp); coeffs (0, 14'h1FFF, 0), pixel 255 -> data_o = 255.
- Height=1, width=5 -> ready_o low for exactly 5 cycles in FLUSH; 5 outputs equal to the input pixels under identity coeffs.
- sof mid-RUN (frame A 8x4, restart at row 2 col 3 with frame B 4x2) -> A's in-flight outputs finish, then exactly 8 outputs for B; non-sof pixels in IDLE are dropped with no output.
- Reset asserted mid-FLUSH -> next cycle valid_o=0 and data_o=0, ready_o returns to 1, FSM is in IDLE.
